// File: rtl/mig1_ram_arbiter_if.sv
// Bundle of the fetch, debug and SimRAM port signals around the RAM arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface mig1_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;

  logic                  d_req;
  logic                  d_we;
  logic                  d_lock;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  locked;

  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_lock, d_addr, d_wdata, ram_rd_data,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, locked,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_lock, d_addr, d_wdata, ram_rd_data,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, locked,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/mig1_ram_arbiter.sv
// Shares SimRAM between instruction fetch and debug access: one op per cycle, round-robin
// on conflict, debug lock for atomic RMW; grants are same-cycle, read data returns 1 cycle later.
module mig1_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  mig1_ram_arbiter_if.slave bus
);

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  owner_t last_gnt;
  logic   lock_q;
  logic   rsp_f_q;
  logic   rsp_d_q;

  logic                  f_gnt_c;
  logic                  d_gnt_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;

  always_comb begin
    f_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (!rst) begin
      if (lock_q) begin
        d_gnt_c = bus.d_req;
      end else if (bus.f_req && bus.d_req) begin
        // Tie: whoever did not win last time goes now.
        if (last_gnt == OWN_D) f_gnt_c = 1'b1;
        else                   d_gnt_c = 1'b1;
      end else begin
        f_gnt_c = bus.f_req;
        d_gnt_c = bus.d_req;
      end
    end
  end

  always_comb begin
    rd_addr_c = bus.d_addr;
    if (f_gnt_c) rd_addr_c = bus.f_addr;
  end

  assign bus.f_gnt       = f_gnt_c;
  assign bus.d_gnt       = d_gnt_c;
  assign bus.ram_rd_en   = f_gnt_c | (d_gnt_c & ~bus.d_we);
  assign bus.ram_rd_addr = rd_addr_c;
  assign bus.ram_wr_en   = d_gnt_c & bus.d_we;
  assign bus.ram_wr_addr = bus.d_addr;
  assign bus.ram_wr_data = bus.d_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= OWN_D;
      lock_q   <= 1'b0;
      rsp_f_q  <= 1'b0;
      rsp_d_q  <= 1'b0;
    end else begin
      if (f_gnt_c)      last_gnt <= OWN_F;
      else if (d_gnt_c) last_gnt <= OWN_D;

      rsp_f_q <= f_gnt_c;
      rsp_d_q <= d_gnt_c & ~bus.d_we;

      // Dropping d_lock releases ownership even while that cycle's debug op is granted.
      if (lock_q && !bus.d_lock)    lock_q <= 1'b0;
      else if (d_gnt_c && bus.d_lock) lock_q <= 1'b1;
    end
  end

  assign bus.f_rvalid = rsp_f_q & ~rst;
  assign bus.d_rvalid = rsp_d_q & ~rst;
  assign bus.f_rdata  = bus.f_rvalid ? bus.ram_rd_data : {DATA_WIDTH{1'b0}};
  assign bus.d_rdata  = bus.d_rvalid ? bus.ram_rd_data : {DATA_WIDTH{1'b0}};
  assign bus.locked   = lock_q & ~rst;

endmodule

// File: tb/tb_mig1_ram_arbiter.sv
// Bench for mig1_ram_arbiter: SimRAM stand-in, per-cycle reference model, directed vectors.
module tb_mig1_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mig1_ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mig1_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return 32'hC0DE0000 | {24'h0, a};
  endfunction

  // SimRAM: write at the edge, registered read.
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
    end else begin
      if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
      if (bus.ram_rd_en) rd_q <= mem[bus.ram_rd_addr];
    end
  end
  assign bus.ram_rd_data = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who should own the RAM this cycle, and what each requester sees next.
  initial begin
    logic [31:0] shadow [256];
    logic        m_last_d = 1'b1;
    logic        m_lock = 1'b0;
    logic        m_pf = 1'b0, m_pd = 1'b0;
    logic [31:0] m_fdat = '0, m_ddat = '0;
    logic        e_fg, e_dg, e_frv, e_drv, e_lock, e_rd, e_wr;
    forever begin
      @(negedge clk);
      if (mem_load) for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
      e_fg = 1'b0; e_dg = 1'b0; e_frv = 1'b0; e_drv = 1'b0; e_lock = 1'b0;
      if (!rst) begin
        e_lock = m_lock;
        e_frv  = m_pf;
        e_drv  = m_pd;
        if (m_lock)                       e_dg = bus.d_req;
        else if (bus.f_req && bus.d_req) begin
          e_fg = m_last_d;
          e_dg = !m_last_d;
        end else begin
          e_fg = bus.f_req;
          e_dg = bus.d_req;
        end
      end
      e_rd = e_fg || (e_dg && !bus.d_we);
      e_wr = e_dg && bus.d_we;

      chk("f_gnt", 32'(bus.f_gnt), 32'(e_fg));
      chk("d_gnt", 32'(bus.d_gnt), 32'(e_dg));
      chk("f_rvalid", 32'(bus.f_rvalid), 32'(e_frv));
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_drv));
      chk("f_rdata", bus.f_rdata, e_frv ? m_fdat : 32'h0);
      chk("d_rdata", bus.d_rdata, e_drv ? m_ddat : 32'h0);
      chk("locked", 32'(bus.locked), 32'(e_lock));
      chk("ram_rd_en", 32'(bus.ram_rd_en), 32'(e_rd));
      chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(e_wr));
      if (e_rd) chk("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(e_fg ? bus.f_addr : bus.d_addr));
      if (e_wr) begin
        chk("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(bus.d_addr));
        chk("ram_wr_data", bus.ram_wr_data, bus.d_wdata);
      end

      if (rst) begin
        m_last_d = 1'b1; m_lock = 1'b0; m_pf = 1'b0; m_pd = 1'b0;
      end else begin
        if (e_fg) m_last_d = 1'b0;
        if (e_dg) m_last_d = 1'b1;
        m_pf   = e_fg;
        m_fdat = shadow[bus.f_addr];
        m_pd   = e_dg && !bus.d_we;
        m_ddat = shadow[bus.d_addr];
        if (e_wr) shadow[bus.d_addr] = bus.d_wdata;
        if (m_lock && !bus.d_lock)    m_lock = 1'b0;
        else if (e_dg && bus.d_lock)  m_lock = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0;
    bus.d_addr = '0;  bus.d_wdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    mem_load = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst_f_gnt", 32'(bus.f_gnt), 32'h0);
    chk("rst_locked", 32'(bus.locked), 32'h0);
    step();
    step();
    mem_load = 1'b0;
    rst = 1'b0;

    // Uncontested fetch stream at 0x10.
    bus.f_req = 1'b1; bus.f_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_f_gnt", 32'(bus.f_gnt), 32'h1);
      if (i > 0) chk("stream_f_rdata", bus.f_rdata, 32'hC0DE0010);
      chk("stream_d_rvalid", 32'(bus.d_rvalid), 32'h0);
      step();
    end
    bus.f_req = 1'b0;
    @(negedge clk);
    chk("stream_last_rvalid", 32'(bus.f_rvalid), 32'h1);
    step();

    // Continuous tie straight out of reset: F,D,F,D,F,D.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 8'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h40;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("tie_f_gnt", 32'(bus.f_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("tie_d_gnt", 32'(bus.d_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
      if (i % 2 == 1) chk("tie_f_rdata", bus.f_rdata, 32'hC0DE0020);
      if (i > 0 && i % 2 == 0) chk("tie_d_rdata", bus.d_rdata, 32'hC0DE0040);
      step();
    end
    // Last winner was debug, so the next tie goes to fetch.
    @(negedge clk);
    chk("tie2_f_gnt", 32'(bus.f_gnt), 32'h1);
    step();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_rd_en", 32'(bus.ram_rd_en), 32'h0);
      chk("idle_wr_en", 32'(bus.ram_wr_en), 32'h0);
      step();
    end
    bus.f_req = 1'b1; bus.f_addr = 8'h20;
    bus.d_req = 1'b1; bus.d_addr = 8'h40;
    @(negedge clk);
    chk("tie3_d_gnt", 32'(bus.d_gnt), 32'h1);
    step();
    idle_inputs();

    // Debug write then read-back of the same word.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h08; bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_en_pulse", 32'(bus.ram_wr_en), 32'h1);
    step();
    bus.d_we = 1'b0;
    @(negedge clk);
    chk("wr_no_rvalid", 32'(bus.d_rvalid), 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("rb_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    step();

    // Locked read-modify-write of 0x0C with fetch pushing.
    bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 8'h0C;
    @(negedge clk);
    chk("lock_rd_gnt", 32'(bus.d_gnt), 32'h1);
    step();
    bus.d_req = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 8'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_f_blocked", 32'(bus.f_gnt), 32'h0);
      chk("lock_held", 32'(bus.locked), 32'h1);
      if (i == 0) chk("lock_rd_data", bus.d_rdata, 32'hC0DE000C);
      step();
    end
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b0; bus.d_wdata = 32'h12345678;
    @(negedge clk);
    chk("unlock_wr_gnt", 32'(bus.d_gnt), 32'h1);
    chk("unlock_f_blocked", 32'(bus.f_gnt), 32'h0);
    step();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    chk("unlock_released", 32'(bus.locked), 32'h0);
    chk("unlock_f_gnt", 32'(bus.f_gnt), 32'h1);
    step();

    // Reset right after a fetch grant swallows its response.
    rst = 1'b1;
    bus.d_req = 1'b1; bus.d_addr = 8'h40;
    @(negedge clk);
    chk("rst_kill_rvalid", 32'(bus.f_rvalid), 32'h0);
    chk("rst_no_gnt", 32'(bus.f_gnt | bus.d_gnt), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_f_first", 32'(bus.f_gnt), 32'h1);
    step();
    @(negedge clk);
    chk("post_rst_d_next", 32'(bus.d_gnt), 32'h1);
    step();
    idle_inputs();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mig1_ram_arbiter.md
# mig1_ram_arbiter

Two-requester arbiter that shares the Mig1 SimRAM between the core instruction-fetch path and the debug memory-access path driven from the debug APB slave. It sits between `Mig1Core`/debug logic and `SimRAM` inside `Mig1CPU`, replacing the direct fetch-to-RAM wiring. It serializes accesses to one operation per cycle, grants round-robin on conflict, supports a debug lock for atomic read-modify-write, and routes registered read data back to the requester that issued the read.

## Interface
- `ADDR_WIDTH`, 8, byte address width, matching SimRAM
- `DATA_WIDTH`, 32, word width
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `f_req`  in  1  fetch read request
- `f_addr`  in  ADDR_WIDTH  fetch address
- `f_gnt`  out  1  fetch request accepted this cycle
- `f_rvalid`  out  1  fetch read data valid
- `f_rdata`  out  DATA_WIDTH  fetch read data
- `d_req`  in  1  debug request
- `d_we`  in  1  debug write (1) / read (0)
- `d_lock`  in  1  debug requests exclusive ownership
- `d_addr`  in  ADDR_WIDTH  debug address
- `d_wdata`  in  DATA_WIDTH  debug write data
- `d_gnt`  out  1  debug request accepted this cycle
- `d_rvalid`  out  1  debug read data valid
- `d_rdata`  out  DATA_WIDTH  debug read data
- `locked`  out  1  debug lock held
- `ram_rd_en`, `ram_rd_addr`  out  1 / ADDR_WIDTH  to SimRAM read port
- `ram_rd_data`  in  DATA_WIDTH  SimRAM read data, valid one cycle after `ram_rd_en`
- `ram_wr_en`, `ram_wr_addr`, `ram_wr_data`  out  1 / ADDR_WIDTH / DATA_WIDTH  to SimRAM write port

## Operation
- State: `last_gnt` (0=fetch, 1=debug), `lock_q`, `rsp_f_q`, `rsp_d_q`.
- At most one of `f_gnt`/`d_gnt` per cycle. Grants are combinational from the requests and state.
- `lock_q`=1: `f_gnt`=0, and `d_gnt`=`d_req`.
- Otherwise, only one request asserted: that request is granted.
- Otherwise, both requests asserted: grant `~last_gnt`, so the requester that was not granted last wins.
- On any grant, `last_gnt` updates to the granted requester. With no grant it holds.
- Requesters hold `*_req`, address, data, `d_we` and `d_lock` stable until granted.
- Fetch grant: `ram_rd_en`=1, `ram_rd_addr`=`f_addr`.
- Debug read grant: `ram_rd_en`=1, `ram_rd_addr`=`d_addr`.
- Debug write grant: `ram_wr_en`=1, `ram_wr_addr`=`d_addr`, `ram_wr_data`=`d_wdata`, no read response.
- RAM enables are 0 whenever there is no grant.
- Response routing: `rsp_f_q` <= `f_gnt`; `rsp_d_q` <= `d_gnt & ~d_we`.
  - `f_rvalid`=`rsp_f_q`, `d_rvalid`=`rsp_d_q`.
  - `*_rdata`=`ram_rd_data` when the matching rvalid is 1, else 0.
- Lock:
  - `lock_q` <= 1 on a debug grant with `d_lock`=1.
  - `lock_q` <= 0 in any cycle where `lock_q`=1 and `d_lock`=0; `d_req` in that same cycle is still granted.
  - `locked`=`lock_q`.
- Address width: addresses pass through unmodified. Word alignment is the requester's responsibility.

## Timing
- Reset values: `last_gnt`=1 (fetch wins the first tie); `lock_q`, `rsp_f_q`, `rsp_d_q` = 0.
- While `rst`=1:
  - All grants and RAM enables are forced to 0.
  - `f_rvalid`, `d_rvalid`, `locked` = 0.
  - `*_rdata` = 0.
- Reset mid-operation: a read granted in the cycle before `rst` produces no rvalid. Lock is dropped.
- Grant latency: 0 cycles, same cycle as `*_req` when uncontested.
- Read latency: rvalid and data appear exactly 1 cycle after grant.
- Back-to-back reads by one requester are sustained at 1 per cycle when uncontested.
- Under continuous dual requests, grants alternate F,D,F,D and neither side waits more than 1 cycle.
- Write: takes effect at the clock edge of the grant cycle. A read of the same address granted the next cycle returns the new data.

## Test plan
- Reset then `f_req`=1, `f_addr`=0x10 for 4 cycles -> `f_gnt`=1 every cycle, and `f_rvalid`=1 one cycle later with RAM words 0x10,0x10,... ; `d_*` outputs stay 0.
- Both requests held 6 cycles (f 0x20, d read 0x40) from reset -> grant sequence F,D,F,D,F,D; the rvalid of each requester lags its grant by 1 cycle with matching data.
- Debug write 0xDEADBEEF to 0x08, then debug read 0x08 the next cycle -> `ram_wr_en` pulse, then `d_rvalid`=1 with `d_rdata`=0xDEADBEEF; `d_rvalid` is never asserted for the write.
- Debug lock sequence: read 0x0C with `d_lock`=1, idle 3 cycles with `d_lock`=1 while `f_req`=1, then write 0x0C with `d_lock`=0 -> `f_gnt`=0 for all locked cycles; write granted; `locked` falls after the write cycle; `f_gnt`=1 the following cycle.
- Assert `rst` the cycle after a fetch grant -> `f_rvalid` stays 0; after reset release with both requesting, fetch is granted first.
- Idle cycles with no requests -> `ram_rd_en`=`ram_wr_en`=0 and `last_gnt` is unchanged, checked by the next tie outcome.
